// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width and the ALU opcodes that the decoder owns.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam int unsigned ALU_OP_W = 5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ROUND = 5'h1a;

  // Power of two with only bit (width-1) set; used as the overflow threshold.
  function automatic logic [DATA_W-1:0] msb_of(input int unsigned width);
    logic [DATA_W-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/msb_smear.sv
// Pure combinational right-smear: every bit at or below the highest set bit becomes 1.
module msb_smear
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] s;

  // log2(WIDTH) OR stages with doubling shift distance.
  always_comb begin
    s = din;
    for (int unsigned sh = 1; sh < WIDTH; sh = sh * 2) begin
      s = s | (s >> sh);
    end
    dout = s;
  end

endmodule

// File: rtl/round_up_power_of_2.sv
// Registered round-up-to-power-of-two ALU helper: rounded = smear(op1 - 1) + 1, one cycle latency.
module round_up_power_of_2
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] rounded,
  output logic             out_valid,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] smeared;
  logic [WIDTH-1:0] rounded_d, rounded_q;
  logic             overflow_d, overflow_q;
  logic             out_valid_q;

  // Modular wraparound maps op1 = 0 and op1 > MSB to 0.
  assign dec = op1 - ONE;

  msb_smear #(
    .WIDTH(WIDTH)
  ) u_smear (
    .din (dec),
    .dout(smeared)
  );

  assign rounded_d  = smeared + ONE;
  assign overflow_d = (op1 > MSB);

  always_ff @(posedge clk) begin
    if (rst) begin
      rounded_q   <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        rounded_q  <= rounded_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign rounded   = rounded_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_round_up_power_of_2.sv
// Self-checking bench for round_up_power_of_2 against a loop-based power-of-two reference.
module tb_round_up_power_of_2;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] op1;
  logic [W-1:0] rounded;
  logic         out_valid;
  logic         overflow;

  int errors;
  int checks;

  round_up_power_of_2 #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .op1      (op1),
    .rounded  (rounded),
    .out_valid(out_valid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Smallest power of two >= n by repeated doubling; results that need bit W overflow.
  function automatic void ref_round(input int unsigned n, output logic [W-1:0] r, output logic o);
    int unsigned p;
    r = '0;
    o = 1'b0;
    if (n != 0) begin
      p = 1;
      while (p < n) p = p * 2;
      if (p >= (1 << W)) begin
        r = '0;
        o = 1'b1;
      end else begin
        r = p[W-1:0];
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    op1 = 8'd200;
    step();
    step();
    checks++;
    if ({rounded, overflow, out_valid} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rounded=%0d ovf=%0b vld=%0b, expected 0/0/0",
               rounded, overflow, out_valid);
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_zero();
    in_valid = 1'b1;
    op1 = 8'd0;
    step();
    in_valid = 1'b0;
    checks++;
    if ({rounded, overflow, out_valid} !== {8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero: rounded=%0d ovf=%0b vld=%0b, expected 0/0/1",
               rounded, overflow, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ops [5];
    logic [W-1:0] exp [5];
    ops = '{8'd5, 8'd7, 8'd9, 8'd16, 8'd17};
    exp = '{8'd8, 8'd8, 8'd16, 8'd16, 8'd32};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op1 = ops[i];
      step();
      checks++;
      if ({rounded, overflow, out_valid} !== {exp[i], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL back_to_back op=%0d: rounded=%0d ovf=%0b vld=%0b, expected %0d/0/1",
                 ops[i], rounded, overflow, out_valid, exp[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ops [7];
    logic [W-1:0] exp [7];
    logic         eov [7];
    ops = '{8'd1, 8'd2, 8'd3, 8'd127, 8'd128, 8'd129, 8'd255};
    exp = '{8'd1, 8'd2, 8'd4, 8'd128, 8'd128, 8'd0, 8'd0};
    eov = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op1 = ops[i];
      step();
      checks++;
      if ({rounded, overflow, out_valid} !== {exp[i], eov[i], 1'b1}) begin
        errors++;
        $display("FAIL boundary op=%0d: rounded=%0d ovf=%0b vld=%0b, expected %0d/%0b/1",
                 ops[i], rounded, overflow, out_valid, exp[i], eov[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gap();
    in_valid = 1'b1;
    op1 = 8'd9;
    step();
    checks++;
    if ({rounded, overflow, out_valid} !== {8'd16, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL gap_first: rounded=%0d ovf=%0b vld=%0b, expected 16/0/1",
               rounded, overflow, out_valid);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op1 = 8'd200 + 8'(i);
      step();
      checks++;
      if ({rounded, overflow, out_valid} !== {8'd16, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL gap_hold%0d: rounded=%0d ovf=%0b vld=%0b, expected 16/0/0",
                 i, rounded, overflow, out_valid);
      end
    end
  endtask

  task automatic test_reset_priority();
    in_valid = 1'b1;
    op1 = 8'd200;
    step();
    checks++;
    if ({rounded, overflow, out_valid} !== {8'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: rounded=%0d ovf=%0b vld=%0b, expected 0/1/1",
               rounded, overflow, out_valid);
    end
    op1 = 8'd17;
    step();
    rst = 1'b1;
    op1 = 8'd5;
    step();
    checks++;
    if ({rounded, overflow, out_valid} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_priority: rounded=%0d ovf=%0b vld=%0b, expected 0/0/0",
               rounded, overflow, out_valid);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    checks++;
    if ({rounded, overflow, out_valid} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_discard: rounded=%0d ovf=%0b vld=%0b, expected 0/0/0",
               rounded, overflow, out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] er;
    logic         eo;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      op1 = 8'(i);
      step();
      ref_round(i, er, eo);
      checks++;
      if ({rounded, overflow, out_valid} !== {er, eo, 1'b1}) begin
        errors++;
        $display("FAIL sweep op=%0d: rounded=%0d ovf=%0b vld=%0b, expected %0d/%0b/1",
                 i, rounded, overflow, out_valid, er, eo);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] er, hr;
    logic         eo, ho;
    int unsigned  n;
    logic         v;
    // Establish a known held value first.
    in_valid = 1'b1;
    op1 = 8'd3;
    step();
    hr = 8'd4;
    ho = 1'b0;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(255, 0);
      v = 1'($urandom_range(1, 0));
      in_valid = v;
      op1 = 8'(n);
      step();
      if (v) begin
        ref_round(n, er, eo);
        hr = er;
        ho = eo;
      end
      checks++;
      if ({rounded, overflow, out_valid} !== {hr, ho, v}) begin
        errors++;
        $display("FAIL random op=%0d v=%0b: rounded=%0d ovf=%0b vld=%0b, expected %0d/%0b/%0b",
                 n, v, rounded, overflow, out_valid, hr, ho, v);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    op1 = '0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_boundaries();
    test_gap();
    test_reset_priority();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
